slot_uart_master: RTL and testbench

Hardware initiator for the UART slot interface: drives the `cs`/`read`/`write`/`addr`/`wr_data` slot bus of a UART slot core and turns it into two byte streams with valid/ready handshakes, one for transmit and one for receive. It sits between on-chip hardware producers and consumers (command parsers, loggers) and a UART slot core. It lets those blocks use the serial link without a processor. It programs the baud divisor after reset, polls status, pushes TX bytes and pops RX bytes.

---
 rtl/slot_uart_master_pkg.sv | 26 ++
 rtl/slot_uart_master_if.sv | 20 ++
 rtl/slot_uart_master_byte_hold_reg.sv | 41 ++++
 rtl/slot_uart_master.sv | 166 ++++++++++++++++
 tb/tb_slot_uart_master.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/slot_uart_master_pkg.sv
`default_nettype none
// ============================================================================
// Module   : slot_uart_master_pkg
// Brief    : Slot register map, status bit positions and FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package slot_uart_master_pkg;

  localparam logic [1:0] ADDR_STATUS = 2'd0;
  localparam logic [1:0] ADDR_DVSR   = 2'd1;
  localparam logic [1:0] ADDR_TX     = 2'd2;
  localparam logic [1:0] ADDR_RX     = 2'd3;

  localparam int TX_FULL_BIT  = 9;
  localparam int RX_EMPTY_BIT = 8;

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_POLL    = 3'd1,
    ST_RX_POP  = 3'd2,
    ST_TX_PUSH = 3'd3,
    ST_CFG     = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/slot_uart_master_if.sv
`default_nettype none
// ============================================================================
// Module   : slot_uart_master_if
// Brief    : UART slot bus (strobes, address, write data, read data).
// Revision : 1.0 - initial release
// ============================================================================
interface slot_uart_master_if;

  logic        cs;
  logic        read;
  logic        write;
  logic [1:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;

  modport master (output cs, read, write, addr, wr_data, input rd_data);
  modport slave  (input cs, read, write, addr, wr_data, output rd_data);

endinterface
`default_nettype wire

// File: rtl/slot_uart_master_byte_hold_reg.sv
`default_nettype none
// ============================================================================
// Module   : byte_hold_reg
// Brief    : Single-entry valid/ready holding register; never loads and
//            unloads in the same cycle, so in_ready is simply "empty".
// Revision : 1.0 - initial release
// ============================================================================
module byte_hold_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  logic             r_full;
  logic [WIDTH-1:0] r_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (!r_full && in_valid) begin
      r_full <= 1'b1;
      r_data <= in_data;
    end else if (r_full && out_ready) begin
      r_full <= 1'b0;
    end
  end

  assign in_ready  = !r_full;
  assign out_valid = r_full;
  assign out_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/slot_uart_master.sv
`default_nettype none
// ============================================================================
// Module   : slot_uart_master
// Brief    : Slot-bus initiator turning a UART slot core into TX/RX byte
//            streams. SLOT_UART_MASTER_CFG_EN adds runtime divisor updates.
// Revision : 1.0 - initial release
// ============================================================================
module slot_uart_master
  import slot_uart_master_pkg::*;
#(
  parameter logic [10:0] DVSR_INIT = 11'd650
) (
  input  logic                      clk,
  input  logic                      reset,
  slot_uart_master_if.master        slot,
  input  logic                      tx_valid,
  input  logic [7:0]                tx_data,
  output logic                      tx_ready,
  output logic                      rx_valid,
  output logic [7:0]                rx_data,
  input  logic                      rx_ready,
  input  logic                      cfg_valid,
  input  logic [10:0]               cfg_dvsr,
  output logic                      cfg_ready
);

  state_t      r_state;
  state_t      w_next_state;
  logic        r_rr_tx_turn;
  logic        w_rr_tx_turn_next;
  logic [7:0]  r_rx_sample;

  logic        w_tx_hold_full;
  logic [7:0]  w_tx_hold_byte;
  logic        w_unused_rx_in_ready;
  logic        w_rx_elig;
  logic        w_tx_elig;

  logic        w_cs;
  logic        w_read;
  logic        w_write;
  logic [1:0]  w_addr;
  logic [31:0] w_wr_data;
  logic        w_cfg_ready;

  wire w_unused_rd = ^slot.rd_data[31:10];

  byte_hold_reg #(.WIDTH(8)) u_tx_hold (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (tx_valid),
    .in_data   (tx_data),
    .in_ready  (tx_ready),
    .out_valid (w_tx_hold_full),
    .out_data  (w_tx_hold_byte),
    .out_ready (r_state == ST_TX_PUSH)
  );

  // Loaded at the end of RX_POP with the head byte captured in the preceding POLL
  byte_hold_reg #(.WIDTH(8)) u_rx_hold (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (r_state == ST_RX_POP),
    .in_data   (r_rx_sample),
    .in_ready  (w_unused_rx_in_ready),
    .out_valid (rx_valid),
    .out_data  (rx_data),
    .out_ready (rx_ready)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_INIT;
      r_rr_tx_turn <= 1'b0;
      r_rx_sample  <= 8'h00;
    end else begin
      r_state      <= w_next_state;
      r_rr_tx_turn <= w_rr_tx_turn_next;
      if (r_state == ST_POLL) begin
        r_rx_sample <= slot.rd_data[7:0];
      end
    end
  end

  // Holding-register terms are pre-edge, so a byte consumed this cycle still blocks a pop
  assign w_rx_elig = !slot.rd_data[RX_EMPTY_BIT] && !rx_valid;
  assign w_tx_elig = !slot.rd_data[TX_FULL_BIT] && w_tx_hold_full;

  always_comb begin
    w_next_state      = r_state;
    w_rr_tx_turn_next = r_rr_tx_turn;
    w_cs              = 1'b0;
    w_read            = 1'b0;
    w_write           = 1'b0;
    w_addr            = ADDR_STATUS;
    w_wr_data         = 32'h0;
    w_cfg_ready       = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_cs         = 1'b1;
        w_write      = 1'b1;
        w_addr       = ADDR_DVSR;
        w_wr_data    = {21'h0, DVSR_INIT};
        w_next_state = ST_POLL;
      end
      ST_POLL: begin
        w_cs   = 1'b1;
        w_read = 1'b1;
`ifdef SLOT_UART_MASTER_CFG_EN
        if (cfg_valid) begin
          w_next_state = ST_CFG;
        end else
`endif
        if (w_rx_elig && (!w_tx_elig || !r_rr_tx_turn)) begin
          w_next_state      = ST_RX_POP;
          w_rr_tx_turn_next = 1'b1;
        end else if (w_tx_elig) begin
          w_next_state      = ST_TX_PUSH;
          w_rr_tx_turn_next = 1'b0;
        end
      end
      ST_RX_POP: begin
        w_cs         = 1'b1;
        w_write      = 1'b1;
        w_addr       = ADDR_RX;
        w_next_state = ST_POLL;
      end
      ST_TX_PUSH: begin
        w_cs         = 1'b1;
        w_write      = 1'b1;
        w_addr       = ADDR_TX;
        w_wr_data    = {24'h0, w_tx_hold_byte};
        w_next_state = ST_POLL;
      end
`ifdef SLOT_UART_MASTER_CFG_EN
      ST_CFG: begin
        w_cs         = 1'b1;
        w_write      = 1'b1;
        w_addr       = ADDR_DVSR;
        w_wr_data    = {21'h0, cfg_dvsr};
        w_cfg_ready  = 1'b1;
        w_next_state = ST_POLL;
      end
`endif
      default: begin
        w_next_state = ST_POLL;
      end
    endcase
  end

  // Reset masks the decode so strobes drop immediately rather than at the next edge
  assign slot.cs      = w_cs    & ~reset;
  assign slot.read    = w_read  & ~reset;
  assign slot.write   = w_write & ~reset;
  assign slot.addr    = reset ? ADDR_STATUS : w_addr;
  assign slot.wr_data = reset ? 32'h0 : w_wr_data;

`ifdef SLOT_UART_MASTER_CFG_EN
  assign cfg_ready = w_cfg_ready & ~reset;
`else
  wire w_unused_cfg = ^{cfg_valid, cfg_dvsr, w_cfg_ready};
  assign cfg_ready = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_slot_uart_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_slot_uart_master
// Brief    : Directed bench for slot_uart_master with a small UART FIFO model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_slot_uart_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        cfg_valid;
  logic [10:0] cfg_dvsr;
  logic        cfg_ready;

  logic        m_tx_full;
  logic [7:0]  m_rx_mem [0:7];
  logic [3:0]  m_rx_wr;
  logic [3:0]  m_rx_rd  = 4'd0;
  int          n_pop    = 0;
  int          n_push   = 0;
  int          n_vec    = 0;
  int          n_err    = 0;

  slot_uart_master_if slot_bus ();

  slot_uart_master dut (
    .clk       (clk),
    .reset     (reset),
    .slot      (slot_bus),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .cfg_valid (cfg_valid),
    .cfg_dvsr  (cfg_dvsr),
    .cfg_ready (cfg_ready)
  );

  always #5 clk = ~clk;

  assign slot_bus.rd_data = {22'h0, m_tx_full, (m_rx_wr == m_rx_rd), m_rx_mem[m_rx_rd[2:0]]};

  always @(posedge clk) begin
    if (!reset && slot_bus.cs && slot_bus.write) begin
      if (slot_bus.addr == 2'd3) begin
        n_pop   <= n_pop + 1;
        m_rx_rd <= m_rx_rd + 4'd1;
      end
      if (slot_bus.addr == 2'd2) n_push <= n_push + 1;
    end
  end

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  task automatic push_rx(input logic [7:0] b);
    m_rx_mem[m_rx_wr[2:0]] = b;
    m_rx_wr = m_rx_wr + 4'd1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b0;
    cfg_valid = 1'b0; cfg_dvsr = 11'd0; m_tx_full = 1'b0; m_rx_wr = 4'd0;
    for (int i = 0; i < 8; i++) m_rx_mem[i] = 8'h00;
    nxt(); nxt();
    chk("rst_cs", slot_bus.cs, 0);       chk("rst_read", slot_bus.read, 0);
    chk("rst_write", slot_bus.write, 0); chk("rst_addr", slot_bus.addr, 0);
    chk("rst_wdata", slot_bus.wr_data, 0);
    chk("rst_rx_valid", rx_valid, 0);    chk("rst_rx_data", rx_data, 0);
    chk("rst_tx_ready", tx_ready, 1);    chk("rst_cfg_ready", cfg_ready, 0);

    reset = 1'b0; #1;
    chk("init_cs", slot_bus.cs, 1);      chk("init_write", slot_bus.write, 1);
    chk("init_read", slot_bus.read, 0);  chk("init_addr", slot_bus.addr, 1);
    chk("init_wdata", slot_bus.wr_data, 650);
    nxt();
    chk("poll_read", slot_bus.read, 1);  chk("poll_addr", slot_bus.addr, 0);
    chk("poll_write", slot_bus.write, 0);
    nxt(); nxt();
    chk("poll_idle_cs", slot_bus.cs, 1); chk("poll_idle_read", slot_bus.read, 1);
    chk("idle_pops", n_pop, 0);          chk("idle_push", n_push, 0);

    // RX pop with consumer stalled
    push_rx(8'h41);
    nxt();
    chk("rxpop_addr", slot_bus.addr, 3); chk("rxpop_write", slot_bus.write, 1);
    chk("rxpop_valid_early", rx_valid, 0);
    nxt();
    chk("rx_valid", rx_valid, 1);        chk("rx_data_41", rx_data, 8'h41);
    chk("rx_back_to_poll", slot_bus.read, 1);
    push_rx(8'h42);
    repeat (10) nxt();
    chk("rx_stall_pops", n_pop, 1);      chk("rx_stall_valid", rx_valid, 1);
    rx_ready = 1'b1;
    nxt();
    rx_ready = 1'b0;
    chk("rx_consumed", rx_valid, 0);     chk("rx_no_pop_same_cycle", slot_bus.read, 1);
    nxt();
    chk("rxpop2_addr", slot_bus.addr, 3);
    nxt();
    chk("rx_data_42", rx_data, 8'h42);
    rx_ready = 1'b1;
    nxt();
    rx_ready = 1'b0;
    chk("rx_pops_2", n_pop, 2);

    // TX push, tx_valid during TX_PUSH, then backpressure
    chk("tx_ready_idle", tx_ready, 1);
    tx_valid = 1'b1; tx_data = 8'h5A;
    nxt();
    tx_valid = 1'b0;
    chk("tx_ready_held", tx_ready, 0);   chk("tx_poll", slot_bus.read, 1);
    nxt();
    chk("txpush_addr", slot_bus.addr, 2); chk("txpush_wdata", slot_bus.wr_data, 32'h5A);
    chk("txpush_write", slot_bus.write, 1);
    tx_valid = 1'b1; tx_data = 8'h77;
    chk("tx_ready_in_push", tx_ready, 0);
    nxt();
    chk("tx_ready_after_push", tx_ready, 1);
    m_tx_full = 1'b1;
    nxt();
    tx_valid = 1'b0;
    chk("tx_ready_occupied", tx_ready, 0);
    repeat (20) nxt();
    chk("txfull_no_push", n_push, 1);    chk("txfull_ready", tx_ready, 0);
    chk("txfull_polling", slot_bus.read, 1);
    m_tx_full = 1'b0;
    nxt();
    chk("txrel_addr", slot_bus.addr, 2); chk("txrel_wdata", slot_bus.wr_data, 32'h77);
    repeat (5) nxt();
    chk("txrel_one_push", n_push, 2);

    // Tie-break: RX served last, so TX must win the simultaneous decision
    m_tx_full = 1'b1; tx_valid = 1'b1; tx_data = 8'hA1; push_rx(8'h61);
    nxt();
    tx_valid = 1'b0;
    chk("rr_rx_first", slot_bus.addr, 3);
    nxt();
    chk("rr_rx_data", rx_data, 8'h61);
    push_rx(8'h62); rx_ready = 1'b1;
    nxt();
    rx_ready = 1'b0; m_tx_full = 1'b0;
    chk("rr_poll", slot_bus.read, 1);
    nxt();
    chk("rr_tx_wins", slot_bus.addr, 2); chk("rr_tx_wdata", slot_bus.wr_data, 32'hA1);
    nxt();
    chk("rr_poll2", slot_bus.read, 1);
    nxt();
    chk("rr_rx_next", slot_bus.addr, 3);
    nxt();
    chk("rr_rx_data2", rx_data, 8'h62);
    rx_ready = 1'b1;
    nxt();
    rx_ready = 1'b0;

    // Continuous traffic in both directions
    push_rx(8'h31); push_rx(8'h32); push_rx(8'h33); push_rx(8'h34);
    rx_ready = 1'b1; tx_valid = 1'b1; tx_data = 8'hC0;
    for (int i = 1; i <= 12; i++) begin
      nxt();
      if (i % 2 == 0) begin
        chk("cont_poll", slot_bus.read, 1);
      end else begin
        chk("cont_action", slot_bus.addr, (i % 4 == 1) ? 3 : 2);
      end
      if (i % 4 == 2) chk("cont_rx_data", rx_data, 8'h31 + i / 4);
      if (i % 4 == 3) chk("cont_tx_wdata", slot_bus.wr_data, 32'hC0);
    end
    tx_valid = 1'b0;
    repeat (4) nxt();
    rx_ready = 1'b0;
    chk("cont_push_total", n_push, 6);   chk("cont_pop_total", n_pop, 8);

    // Runtime divisor request racing a pending RX byte
    cfg_valid = 1'b1; cfg_dvsr = 11'd325; push_rx(8'h55);
    chk("cfg_ready_poll", cfg_ready, 0);
    nxt();
`ifdef SLOT_UART_MASTER_CFG_EN
    chk("cfg_addr", slot_bus.addr, 1);   chk("cfg_wdata", slot_bus.wr_data, 325);
    chk("cfg_write", slot_bus.write, 1); chk("cfg_ready", cfg_ready, 1);
    cfg_valid = 1'b0;
    nxt();
    chk("cfg_ready_drop", cfg_ready, 0); chk("cfg_poll", slot_bus.read, 1);
    nxt();
`else
    cfg_valid = 1'b0;
    chk("cfg_ready_tied", cfg_ready, 0);
`endif
    chk("cfg_then_rxpop", slot_bus.addr, 3);
    nxt();
    chk("cfg_rx_data", rx_data, 8'h55);
    rx_ready = 1'b1;
    nxt();
    rx_ready = 1'b0;

    // Reset in the middle of TX_PUSH
    tx_valid = 1'b1; tx_data = 8'h99;
    nxt();
    tx_valid = 1'b0;
    nxt();
    chk("mid_push_addr", slot_bus.addr, 2);
    #2 reset = 1'b1;
    #1;
    chk("arst_cs", slot_bus.cs, 0);      chk("arst_write", slot_bus.write, 0);
    chk("arst_addr", slot_bus.addr, 0);  chk("arst_wdata", slot_bus.wr_data, 0);
    chk("arst_tx_ready", tx_ready, 1);
    nxt();
    reset = 1'b0; #1;
    chk("reinit_addr", slot_bus.addr, 1); chk("reinit_wdata", slot_bus.wr_data, 650);
    nxt();
    chk("reinit_poll", slot_bus.read, 1);
    repeat (4) nxt();
    chk("reinit_no_push", n_push, 6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
